// File: rtl/shift_exec_pipe.sv
// Two-stage MIPS shift execution unit: stage 1 decodes op and shift amount,
// stage 2 runs a logical-right-shift core (bit-reversed for SLL, sign-filled for SRA).
module shift_exec_pipe #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  input  logic [4:0]        dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [4:0]        out_dest
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and in_ready depends only on stage
  // occupancy and out_ready, never on in_valid.

  logic              s1_valid;
  logic [DATA_W-1:0] s1_rt;
  logic [4:0]        s1_dest;
  logic [4:0]        s1_sa;
  logic              s1_left;
  logic              s1_arith;

  logic              s2_valid;
  logic [DATA_W-1:0] s2_result;
  logic [4:0]        s2_dest;

  logic              s2_adv;
  logic              s1_adv;
  logic              accept;

  logic [DATA_W-1:0] core_in;
  logic [DATA_W-1:0] core_out;
  logic [DATA_W-1:0] stage2_r;

  function automatic logic [DATA_W-1:0] bitrev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] o;
    o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      o[i] = v[DATA_W-1-i];
    end
    return o;
  endfunction

  always_comb begin
    s2_adv   = !s2_valid || out_ready;
    s1_adv   = s1_valid && s2_adv;
    in_ready = !s1_valid || s2_adv;
    accept   = in_valid && in_ready;
  end

  // Left shifts reuse the right-shift core by reversing bits on both sides.
  always_comb begin
    core_in  = s1_left ? bitrev(s1_rt) : s1_rt;
    core_out = core_in >> s1_sa;
    if (s1_arith && s1_rt[DATA_W-1] && (s1_sa != 5'd0)) begin
      core_out = core_out | ~({DATA_W{1'b1}} >> s1_sa);
    end
    stage2_r = s1_left ? bitrev(core_out) : core_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      if (in_ready) begin
        s1_valid <= accept;
      end
    end
  end

  // Data registers hold their contents while empty; a flush cycle loads nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_rt    <= '0;
      s1_dest  <= '0;
      s1_sa    <= '0;
      s1_left  <= 1'b0;
      s1_arith <= 1'b0;
    end else if (accept && !flush) begin
      s1_rt    <= rt;
      s1_dest  <= dest;
      if (op[1:0] == 2'b11) begin
        s1_sa    <= 5'd0;
        s1_left  <= 1'b0;
        s1_arith <= 1'b0;
      end else begin
        s1_sa    <= op[2] ? rs[4:0] : shamt;
        s1_left  <= (op[1:0] == 2'b00);
        s1_arith <= (op[1:0] == 2'b10);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_result <= '0;
      s2_dest   <= '0;
    end else if (s1_adv && !flush) begin
      s2_result <= stage2_r;
      s2_dest   <= s1_dest;
    end
  end

  always_comb begin
    out_valid = s2_valid;
    result    = s2_result;
    out_dest  = s2_dest;
  end

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Bench for shift_exec_pipe: directed vector table, hand-written stall, flush
// and async-reset sequences, and randomized traffic against an arithmetic model.
module tb_shift_exec_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [4:0]  shamt;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [4:0]  dest;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  out_dest;

  int total;
  int bad;
  int pops;

  logic [36:0] exp_q[$];
  logic        stall_prev;
  logic [36:0] held;
  logic        rand_done;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  shamt;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  dest;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  shift_exec_pipe #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .shamt(shamt), .rs(rs), .rt(rt), .dest(dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_dest(out_dest)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: shifts computed with plain SystemVerilog shift operators.
  function automatic logic [36:0] model(input logic [2:0] o, input logic [4:0] s,
                                        input logic [31:0] a, input logic [31:0] v,
                                        input logic [4:0] d);
    int unsigned amt;
    logic [31:0] r;
    amt = o[2] ? int'(a[4:0]) : int'(s);
    case (o[1:0])
      2'b00:   r = v << amt;
      2'b01:   r = v >> amt;
      2'b10:   r = $unsigned($signed(v) >>> amt);
      default: r = v;
    endcase
    return {d, r};
  endfunction

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) check("hold_stable", {27'd0, out_dest, result}, {27'd0, held});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got %h with no request outstanding", {out_dest, result});
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          check("scoreboard", {27'd0, out_dest, result}, {27'd0, e});
          pops++;
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {out_dest, result};
      if (in_valid && in_ready) exp_q.push_back(model(op, shamt, rs, rt, dest));
    end
  end

  // driver tasks
  task automatic push(input logic [2:0] o, input logic [4:0] s, input logic [31:0] a,
                      input logic [31:0] v, input logic [4:0] d);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    op = o; shamt = s; rs = a; rt = v; dest = d;
    in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL push_timeout: in_ready stayed %b for %0d cycles", in_ready, n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send_one(input int idx);
    vec_t v;
    v = vecs[idx];
    op = v.op; shamt = v.shamt; rs = v.rs; rt = v.rt; dest = v.dest;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check($sformatf("vec%0d_in_ready", idx), 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check($sformatf("vec%0d_lat1_valid", idx), 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check($sformatf("vec%0d_lat2_valid", idx), 64'(out_valid), 64'd1);
    check($sformatf("vec%0d_result", idx), 64'(result), 64'(v.exp));
    check($sformatf("vec%0d_dest", idx), 64'(out_dest), 64'(v.dest));
    @(posedge clk); #1;
  endtask

  initial begin
    int pops_before;
    logic [31:0] r_hold;
    total = 0; bad = 0; pops = 0;
    stall_prev = 1'b0; held = '0; rand_done = 1'b0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; shamt = '0; rs = '0; rt = '0; dest = '0;

    vecs[0]  = '{3'b001, 5'd4,  32'h0,         32'hF000_000F, 5'd1,  32'h0F00_0000};
    vecs[1]  = '{3'b010, 5'd4,  32'h0,         32'h8000_0010, 5'd2,  32'hF800_0001};
    vecs[2]  = '{3'b110, 5'd9,  32'hFFFF_FFE0, 32'h8765_4321, 5'd3,  32'h8765_4321};
    vecs[3]  = '{3'b000, 5'd31, 32'h0,         32'h0000_0001, 5'd4,  32'h8000_0000};
    vecs[4]  = '{3'b100, 5'd0,  32'h0000_0008, 32'h00AB_CDEF, 5'd5,  32'hABCD_EF00};
    vecs[5]  = '{3'b010, 5'd0,  32'h0,         32'h8000_0000, 5'd6,  32'h8000_0000};
    vecs[6]  = '{3'b001, 5'd31, 32'h0,         32'h8000_0000, 5'd7,  32'h0000_0001};
    vecs[7]  = '{3'b000, 5'd31, 32'h0,         32'h0000_0003, 5'd8,  32'h8000_0000};
    vecs[8]  = '{3'b010, 5'd31, 32'h0,         32'h8000_0000, 5'd9,  32'hFFFF_FFFF};
    vecs[9]  = '{3'b010, 5'd31, 32'h0,         32'h7FFF_FFFF, 5'd10, 32'h0000_0000};
    vecs[10] = '{3'b011, 5'd7,  32'h0,         32'hDEAD_BEEF, 5'd11, 32'hDEAD_BEEF};
    vecs[11] = '{3'b111, 5'd3,  32'h0000_0005, 32'h1234_5678, 5'd12, 32'h1234_5678};
    vecs[12] = '{3'b101, 5'd0,  32'h0000_0024, 32'hF000_0000, 5'd13, 32'h0F00_0000};
    vecs[13] = '{3'b110, 5'd0,  32'h0000_0001, 32'h8000_0001, 5'd31, 32'hC000_0000};

    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_result", 64'(result), 64'd0);
    check("rst_out_dest", 64'(out_dest), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 14; i++) send_one(i);
    drain();

    // streaming with a 3-cycle stall after the first result
    out_ready = 1'b1;
    pops_before = pops;
    fork
      begin
        for (int i = 0; i < 4; i++) push(3'b001, 5'(i + 1), 32'h0, 32'hA5A5_0000 + 32'(i), 5'(20 + i));
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("stream_first_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        r_hold = result;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stream_in_ready_low", 64'(in_ready), 64'd0);
          check("stream_result_hold", 64'(result), 64'(r_hold));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("stream_count", 64'(pops - pops_before), 64'd4);

    // flush with both stages full and a request presented
    out_ready = 1'b0;
    push(3'b000, 5'd1, 32'h0, 32'h1111_1111, 5'd1);
    push(3'b000, 5'd2, 32'h0, 32'h2222_2222, 5'd2);
    check("flush_pre_full", 64'({out_valid, in_ready}), 64'b10);
    pops_before = pops;
    op = 3'b001; shamt = 5'd3; rt = 32'h3333_3333; dest = 5'd3;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("flush_nothing_out", 64'(pops), 64'(pops_before));
    push(3'b010, 5'd8, 32'h0, 32'h8000_1234, 5'd17);
    drain();
    check("flush_after_count", 64'(pops - pops_before), 64'd1);

    // asynchronous reset between edges with work in flight
    out_ready = 1'b0;
    push(3'b001, 5'd1, 32'h0, 32'h0000_00F0, 5'd4);
    push(3'b001, 5'd2, 32'h0, 32'h0000_0F00, 5'd5);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_result", 64'(result), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pops_before = pops;
    out_ready = 1'b1;
    push(3'b100, 5'd0, 32'h0000_0004, 32'h0000_0ABC, 5'd9);
    drain();
    check("arst_fresh_count", 64'(pops - pops_before), 64'd1);

    // randomized traffic with random backpressure
    pops_before = pops;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          push(3'($urandom_range(0, 7)), 5'($urandom), $urandom, $urandom, 5'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("random_count", 64'(pops - pops_before), 64'd150);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_exec_pipe.md
# shift_exec_pipe

Two-stage pipelined shift execution unit for the MIPS EX stage, sitting directly upstream of the combinational logical-right-shift core. Stage 1 decodes the shift operation (SLL/SRL/SRA and the variable forms SLLV/SRLV/SRAV) and resolves the shift amount from `shamt` or `rs[4:0]`. Stage 2 drives the right-shift core, using bit reversal for left shifts and sign fill for arithmetic shifts, then registers the result. Valid/ready handshakes on both sides let it stall with the pipeline; `flush` squashes in-flight work.

## Interface
Parameters:
- `DATA_W`, 32: operand/result width; only 32 is supported (shift amount is 5 bits).

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  synchronous squash of both stages
- `in_valid`  in  1  request present
- `in_ready`  out  1  unit accepts request this cycle
- `op`  in  3  000 SLL, 001 SRL, 010 SRA, 100 SLLV, 101 SRLV, 110 SRAV; 011/111 = pass-through
- `shamt`  in  5  immediate shift amount (fixed forms)
- `rs`  in  32  variable shift amount source, low 5 bits used
- `rt`  in  32  value to shift
- `dest`  in  5  destination register tag, carried alongside
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer accepts result
- `result`  out  32  shifted value
- `out_dest`  out  5  tag of the result

## Operation
- Stage 1 register (s1) on accept (`in_valid && in_ready`):
  - stores `rt` and `dest`;
  - `sa = op[2] ? rs[4:0] : shamt`;
  - `left = (op[1:0]==00)`, `arith = (op[1:0]==10)`;
  - `op[1:0]==11` forces `sa=0`, `left=0`, `arith=0`, so `result = rt`.
- Stage 2 combinational path from s1:
  - `x = left ? bitrev(rt) : rt`
  - `y = srl(x, sa)`, zero-filled
  - if `arith && rt[31] && sa!=0`, OR `~(32'hFFFFFFFF >> sa)` into `y`, setting the top `sa` bits
  - `r = left ? bitrev(y) : y`
- Stage 2 register (s2) latches `r` and `dest` when s1 advances.
- Advance rules:
  - `s2_adv = !s2_valid || out_ready`
  - `s1_adv = s1_valid && s2_adv`
  - `in_ready = !s1_valid || s2_adv`
- Valid update on a normal cycle:
  - `s2_valid <= s1_valid` when `s2_adv`;
  - otherwise `s2_valid` is cleared only by `out_ready`.
  - `s1_valid` takes the accept result whenever s1 is empty or advancing.
- `flush`:
  - clears `s1_valid` and `s2_valid` at the next edge and overrides any accept or advance in that cycle;
  - `in_ready` is still computed normally, but a request presented alongside `flush` is dropped.
- Data registers load only on accept/advance. Values are held, not cleared, when valid is low.

## Timing
- Reset values: `s1_valid=0`, `s2_valid=0`, `out_valid=0`, `in_ready=1`, `result=0`, `out_dest=0`, all internal data 0.
- Reset is asynchronous: asserting `rst` mid-operation clears both valids immediately, with no completion of in-flight work.
- Latency: a request accepted at edge N appears on `out_valid/result` after edge N+1, i.e. 2 cycles, with no stall.
- Throughput: 1 result per cycle with `out_ready` held high.
- Backpressure:
  - with `out_ready=0` and both stages full, `in_ready=0`;
  - `result` and `out_dest` hold stable while `out_valid && !out_ready`.
- Simultaneous pop and push with both stages full: s2 takes s1, s1 takes the new input, no bubble.
- `sa=0` returns `rt` unchanged for every op, including SRA with negative `rt`.
- `sa=31`:
  - SRL yields `{31'b0, rt[31]}`;
  - SLL yields `{rt[0], 31'b0}`;
  - SRA yields all bits equal to `rt[31]`.
- No combinational path from `in_valid` to `in_ready`.
- `out_ready` feeds `in_ready` combinationally.

## Test plan
- Reset then `op=001`, `shamt=4`, `rt=32'hF000_000F`, `out_ready=1`: `result=32'h0F00_0000` two cycles after accept; `out_dest` matches.
- `op=010`, `shamt=4`, `rt=32'h8000_0010` → `32'hF800_0001`. `op=110`, `rs=32'hFFFF_FFE0` (`sa=0`) → `rt` unchanged.
- `op=000`, `shamt=31`, `rt=1` → `32'h8000_0000`. `op=100`, `rs=8`, `rt=32'h00AB_CDEF` → `32'hABCD_EF00`.
- Streaming at full rate:
  - issue 4 back-to-back requests;
  - hold `out_ready=0` for 3 cycles after the first result: `in_ready` drops once both stages are full, `result` stays stable;
  - release: all 4 results arrive in order with no loss or duplication.
- `flush`:
  - assert `flush` with both stages full and a request presented: next cycle `out_valid=0`, `in_ready=1`, and the flushed and dropped requests never appear;
  - a following request completes normally.
- Assert `rst` asynchronously mid-stream, between clock edges: `out_valid` drops immediately; after deassertion the unit accepts and produces fresh results.
